// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the multiplier datapath and its
// normalise/round stage: format widths, special-case codes and constant words.
package fp_pkg;

    function automatic int exp_w(input int n);
        return (n == 64) ? 11 : 8;
    endfunction

    function automatic int man_w(input int n);
        return (n == 64) ? 52 : 23;
    endfunction

    function automatic int bias(input int n);
        return (1 << (exp_w(n) - 1)) - 1;
    endfunction

    // Constants are returned 64 bits wide; callers truncate to N.
    function automatic logic [63:0] qnan_of(input int n);
        return (n == 64) ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
    endfunction

    function automatic logic [63:0] inf_of(input int n);
        return (n == 64) ? 64'h7FF0_0000_0000_0000 : 64'h0000_0000_7F80_0000;
    endfunction

    typedef enum logic [1:0] {
        FP_NORMAL = 2'b00,
        FP_ZERO   = 2'b01,
        FP_INF    = 2'b10,
        FP_NAN    = 2'b11
    } fp_special_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } norm_state_e;

endpackage

// File: rtl/fp_norm_round_if.sv
// Load/result bundle between the multiplier core and the normalise/round stage.
interface fp_norm_round_if #(parameter int N = 32);
    import fp_pkg::*;

    localparam int E = exp_w(N);
    localparam int M = man_w(N);

    logic             load;
    logic             in_sign;
    logic [E+1:0]     in_exp;
    logic [2*M+1:0]   in_mant;
    logic [1:0]       in_special;
    logic [N-1:0]     result;
    logic             valid;
    logic             busy;
    logic             overflow;
    logic             underflow;
    logic             inexact;

    modport master (
        output load, in_sign, in_exp, in_mant, in_special,
        input  result, valid, busy, overflow, underflow, inexact
    );

    modport slave (
        input  load, in_sign, in_exp, in_mant, in_special,
        output result, valid, busy, overflow, underflow, inexact
    );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised significand; a carry-out is already
// folded back into sig_o so the caller only has to bump the exponent.
module fp_round_rne #(parameter int M = 23) (
    input  logic [M:0] sig_i,
    input  logic       guard_i,
    input  logic       sticky_i,
    output logic [M:0] sig_o,
    output logic       carry_o,
    output logic       inexact_o
);
    logic         inc;
    logic [M+1:0] sum;

    always_comb begin
        inc       = guard_i & (sticky_i | sig_i[0]);
        sum       = {1'b0, sig_i} + {{(M+1){1'b0}}, inc};
        carry_o   = sum[M+1];
        sig_o     = carry_o ? sum[M+1:1] : sum[M:0];
        inexact_o = guard_i | sticky_i;
    end

endmodule

// File: rtl/fp_norm_round.sv
// Post-multiply stage: normalises the raw significand product one shift per
// cycle, rounds RNE, clamps the exponent and packs an IEEE-754 word.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    fp_norm_round_if.slave bus
);
    localparam int E  = exp_w(N);
    localparam int M  = man_w(N);
    localparam int MW = 2*M + 2;
    localparam int EW = E + 2;
    localparam logic [N-1:0]  QNAN    = N'(qnan_of(N));
    localparam logic [N-1:0]  INF     = N'(inf_of(N));
    localparam logic [EW-1:0] EXP_MAX = EW'((1 << E) - 1);

    if (N != 32 && N != 64) begin : g_bad_n
        $error("fp_norm_round: N must be 32 or 64");
    end

    norm_state_e   state_q, state_d;
    logic          sign_q, sign_d;
    logic [EW-1:0] exp_q, exp_d;
    logic [MW-1:0] mant_q, mant_d;
    logic          sticky_q, sticky_d;
    fp_special_e   special_q, special_d;
    logic [N-1:0]  result_q, result_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          inx_q, inx_d;

    logic [M:0]    rnd_sig;
    logic          rnd_carry;
    logic          rnd_inexact;
    logic [EW-1:0] exp_rnd;

    fp_round_rne #(.M(M)) u_round (
        .sig_i     (mant_q[2*M:M]),
        .guard_i   (mant_q[M-1]),
        .sticky_i  ((|mant_q[M-2:0]) | sticky_q),
        .sig_o     (rnd_sig),
        .carry_o   (rnd_carry),
        .inexact_o (rnd_inexact)
    );

    // Exponent is two's complement in EW bits; the sign bit catches deep underflow.
    assign exp_rnd = exp_q + EW'(rnd_carry);

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        mant_d    = mant_q;
        sticky_d  = sticky_q;
        special_d = special_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        inx_d     = inx_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.load) begin
                    sign_d    = bus.in_sign;
                    exp_d     = bus.in_exp;
                    mant_d    = bus.in_mant;
                    special_d = fp_special_e'(bus.in_special);
                    sticky_d  = 1'b0;
                    state_d   = (fp_special_e'(bus.in_special) == FP_NORMAL && |bus.in_mant)
                                ? ST_NORM : ST_ROUND;
                end
            end
            ST_NORM: begin
                if (mant_q[MW-1]) begin
                    mant_d   = mant_q >> 1;
                    sticky_d = sticky_q | mant_q[0];
                    exp_d    = exp_q + EW'(1);
                    state_d  = ST_ROUND;
                end else if (mant_q[MW-2]) begin
                    state_d  = ST_ROUND;
                end else begin
                    mant_d   = mant_q << 1;
                    exp_d    = exp_q - EW'(1);
                end
            end
            ST_ROUND: begin
                valid_d = 1'b1;
                state_d = ST_DONE;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                inx_d   = 1'b0;
                case (special_q)
                    FP_NAN:  result_d = QNAN;
                    FP_INF:  result_d = {sign_q, INF[N-2:0]};
                    FP_ZERO: result_d = {sign_q, {(N-1){1'b0}}};
                    default: begin
                        if (mant_q == '0) begin
                            result_d = {sign_q, {(N-1){1'b0}}};
                        end else if (!exp_rnd[EW-1] && exp_rnd >= EXP_MAX) begin
                            result_d = {sign_q, INF[N-2:0]};
                            ovf_d    = 1'b1;
                            inx_d    = 1'b1;
                        end else if (exp_rnd[EW-1] || exp_rnd == '0) begin
                            result_d = {sign_q, {(N-1){1'b0}}};
                            unf_d    = 1'b1;
                            inx_d    = 1'b1;
                        end else begin
                            result_d = {sign_q, exp_rnd[E-1:0], rnd_sig[M-1:0]};
                            inx_d    = rnd_inexact;
                        end
                    end
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mant_q    <= '0;
            sticky_q  <= 1'b0;
            special_q <= FP_NORMAL;
            result_q  <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inx_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            mant_q    <= mant_d;
            sticky_q  <= sticky_d;
            special_q <= special_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            inx_q     <= inx_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = (state_q == ST_NORM) || (state_q == ST_ROUND);
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.inexact   = inx_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed-vector bench for fp_norm_round at N=32 with hand-computed results.
module tb_fp_norm_round;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_norm_round_if #(.N(32)) bus ();

    fp_norm_round #(.N(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Presents a load for one edge; returns 1 ns after that (accepting) edge.
    task automatic apply(input logic s, input logic [9:0] e, input logic [47:0] m, input logic [1:0] sp);
        bus.in_sign    = s;
        bus.in_exp     = e;
        bus.in_mant    = m;
        bus.in_special = sp;
        bus.load       = 1'b1;
        @(posedge clk);
        #1;
        bus.load       = 1'b0;
    endtask

    // Counts edges since acceptance until valid, bounded; notes any busy drop.
    task automatic wait_valid(input int start, output int edges, output bit gap);
        edges = start;
        gap   = 1'b0;
        while (bus.valid !== 1'b1 && edges < 60) begin
            if (bus.busy !== 1'b1) gap = 1'b1;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic run(input string tag, input logic s, input logic [9:0] e,
                       input logic [47:0] m, input logic [1:0] sp,
                       input logic [31:0] exp_res, input int exp_lat,
                       input logic exp_ovf, input logic exp_unf, input logic exp_inx);
        int lat;
        bit gap;
        apply(s, e, m, sp);
        wait_valid(1, lat, gap);
        $display("vector %s: result=%h latency=%0d ovf=%b unf=%b inx=%b",
                 tag, bus.result, lat, bus.overflow, bus.underflow, bus.inexact);
        chk({tag, "_result"}, 64'(bus.result), 64'(exp_res));
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(gap), 64'd0);
        chk({tag, "_ovf"}, 64'(bus.overflow), 64'(exp_ovf));
        chk({tag, "_unf"}, 64'(bus.underflow), 64'(exp_unf));
        chk({tag, "_inx"}, 64'(bus.inexact), 64'(exp_inx));
    endtask

    initial begin
        int lat;
        bit gap;
        int vcount;

        rst            = 1'b1;
        bus.load       = 1'b0;
        bus.in_sign    = 1'b0;
        bus.in_exp     = '0;
        bus.in_mant    = '0;
        bus.in_special = 2'b00;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_valid", 64'(bus.valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ovf", 64'(bus.overflow), 64'd0);
        chk("rst_unf", 64'(bus.underflow), 64'd0);
        chk("rst_inx", 64'(bus.inexact), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run("mul15", 1'b0, 10'd127, 48'h900000000000, 2'b00, 32'h40100000, 3, 1'b0, 1'b0, 1'b0);
        run("ovf",   1'b0, 10'd254, 48'h900000000000, 2'b00, 32'h7F800000, 3, 1'b1, 1'b0, 1'b1);
        run("tie_even", 1'b0, 10'd127, 48'h400000400000, 2'b00, 32'h3F800000, 3, 1'b0, 1'b0, 1'b1);
        run("tie_lsb0", 1'b0, 10'd127, 48'h400001400000, 2'b00, 32'h3F800002, 3, 1'b0, 1'b0, 1'b1);

        // Left normalise by two, with a stray load pulsed while busy.
        apply(1'b0, 10'd127, 48'h100000000000, 2'b00);
        chk("lnorm_busy_e1", 64'(bus.busy), 64'd1);
        bus.load       = 1'b1;
        bus.in_sign    = 1'b1;
        bus.in_special = 2'b11;
        bus.in_mant    = 48'hFFFFFFFFFFFF;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        wait_valid(2, lat, gap);
        $display("vector lnorm: result=%h latency=%0d", bus.result, lat);
        chk("lnorm_result", 64'(bus.result), 64'h3E800000);
        chk("lnorm_latency", 64'(lat), 64'd5);
        chk("lnorm_busy", 64'(gap), 64'd0);
        chk("lnorm_inx", 64'(bus.inexact), 64'd0);

        run("nan", 1'b1, 10'd0, 48'h0, 2'b11, 32'h7FC00000, 2, 1'b0, 1'b0, 1'b0);

        // Reset during the third NORM cycle of a long left normalisation.
        apply(1'b0, 10'd127, 48'h000100000000, 2'b00);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        $display("vector midreset: valid=%b busy=%b result=%h", bus.valid, bus.busy, bus.result);
        chk("midrst_valid", 64'(bus.valid), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_result", 64'(bus.result), 64'd0);
        #10;
        rst = 1'b0;
        vcount = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.valid === 1'b1) vcount++;
        end
        chk("midrst_no_valid", 64'(vcount), 64'd0);

        run("zero_neg", 1'b1, 10'd0, 48'h0, 2'b01, 32'h80000000, 2, 1'b0, 1'b0, 1'b0);
        run("unf", 1'b0, 10'd0, 48'h400000000000, 2'b00, 32'h00000000, 3, 1'b0, 1'b1, 1'b1);
        run("mul15_again", 1'b0, 10'd127, 48'h900000000000, 2'b00, 32'h40100000, 3, 1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        chk("done_to_idle_valid", 64'(bus.valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
